common_reg_arbiter: RTL and testbench
=====================================

Name: common_reg_arbiter

Overview:
- Shares the common register file (DR0-DR3, CR) between two requesters: req 0 is the core instruction sequencer, req 1 is the debug/load port.
- Drives the register file's shared address bus and write-data bus, and sequences each transfer as a read-capture cycle followed by a write cycle.
- Supports three operations: register-to-register move, immediate load, and read-back to the requester.
- Sits between the core control path and the common register file.

Parameters:
- DATA_WIDTH, 8, register/data width; matches `DATA_WIDTH.
- IDLE_CODE, 4'hF, register-select code that matches no register; driven whenever the bus is not in use.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  2  per-requester request level; held until ack.
- op0, op1  in  2 each  operation: 2'b00 MOVE, 2'b01 LOADI, 2'b10 READ, 2'b11 reserved (treated as READ).
- src0, src1  in  4 each  source register code (MOVE, READ).
- dst0, dst1  in  4 each  destination register code (MOVE, LOADI).
- imm0, imm1  in  DATA_WIDTH each  immediate data (LOADI).
- ack  out  2  one-cycle completion pulse per requester.
- rdata  out  DATA_WIDTH  data captured in the READ phase; valid in the ack cycle and held until the next capture.
- busy  out  1  high while not IDLE.
- addr_bus  out  DATA_WIDTH  [7:4] read select, [3:0] write select, to the register file.
- data_bus_in  out  DATA_WIDTH  write data to the register file.
- data_bus_out  in  DATA_WIDTH  combinational read data from the register file.

Behaviour:
- Reset (async, rst=1), all outputs and state:
  - state=IDLE, addr_bus={IDLE_CODE,IDLE_CODE}, data_bus_in=0.
  - ack=0, rdata=0, busy=0, last_grant=1 (so req 0 wins first).
- Latched per grant: gnt (1 bit), op, src, dst, imm, hold (DATA_WIDTH capture register).
- States:
  - IDLE: if any req bit is set, pick a winner per the arbitration rule, latch its fields, go to RD. Otherwise stay.
  - RD: addr_bus={src,IDLE_CODE}, data_bus_in=0; hold<=data_bus_out at cycle end.
    - LOADI skips the read: addr_bus={IDLE_CODE,IDLE_CODE}, hold<=imm.
    - Next state WR.
  - WR, by op:
    - MOVE/LOADI: addr_bus={IDLE_CODE,dst}, data_bus_in=hold.
    - READ: addr_bus={IDLE_CODE,IDLE_CODE}, rdata<=hold.
    - Next state ACK.
  - ACK: ack[gnt]=1 for exactly this cycle; addr_bus idle; last_grant<=gnt; next IDLE.
- Latency: request sampled in IDLE → ack 3 cycles later. Back-to-back transfers complete every 4 cycles.
- Register file write occurs on the clk edge ending WR. MOVE with src==dst is legal and rewrites the same value.
- addr_bus and data_bus_in are registered outputs, glitch-free. Only one of the two nibbles is ever non-idle in any cycle.
- Arbitration (default): round-robin. When both requests are set, grant the requester other than last_grant. A single request is granted immediately.
- A requester deasserting req before ack: the transfer already granted completes and ack still pulses. Requesters must not change op/src/dst/imm while req is high; the arbiter latches them in IDLE anyway.
- Unmapped src code (not DR0-DR3/CR): hold captures 0, matching the register file's default read value. Unmapped dst: no register written; ack still given.
- Reset asserted mid-transfer: returns to IDLE immediately. A pending WR write is abandoned (no partial write), and no ack is issued.
- busy=1 in RD, WR and ACK.

Optional Feature:
- Macro: COMMON_REG_ARB_RR_EN
- Defined: round-robin arbitration as described above.
- Undefined: fixed priority, req 0 always wins over req 1; last_grant is not implemented and is not needed.

Test Plan:
- Reset: assert rst mid-RD → addr_bus=8'hFF, ack=0, busy=0 the same cycle; after release, no register written.
- LOADI: req0 LOADI dst=DR1 imm=8'hA5 → WR cycle addr_bus[3:0]=DR1 code and data_bus_in=8'hA5; ack[0] on cycle 4; DR1 reads back 8'hA5.
- MOVE then READ: req1 MOVE DR1→DR3, then req1 READ src=DR3 → rdata=8'hA5 with ack[1]; DR3=8'hA5.
- Contention (RR): req=2'b11 held for 4 transfers → grants in order 0,1,0,1; acks spaced 4 cycles apart. Without the macro → 0,0,0,0 while req0 stays high.
- Boundaries: READ from unmapped code 4'h9 → rdata=0; LOADI to dst=IDLE_CODE → no register changes, ack still pulses; req0 dropped in WR → ack[0] still pulses once.

Source files
------------

// File: rtl/common_reg_arbiter.sv
// common_reg_arbiter: shares the common register file (DR0-DR3, CR) between
// the core instruction sequencer (req 0) and the debug/load port (req 1).
// Each granted transfer runs IDLE -> RD (read capture) -> WR (write) -> ACK,
// giving an ack three cycles after the request is sampled in IDLE.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   req[1:0]          per-requester request level, held until ack
//   opN/srcN/dstN/immN  operation fields of requester N (latched at grant)
//                     op: 00 MOVE, 01 LOADI, 10 READ, 11 treated as READ
//   ack[1:0]          one-cycle completion pulse for the granted requester
//   rdata             value captured by a READ, held until the next READ
//   busy              high in RD, WR and ACK
//   addr_bus          [7:4] read select, [3:0] write select (registered)
//   data_bus_in       write data to the register file (registered)
//   data_bus_out      combinational read data from the register file
//
// Configuration: define COMMON_REG_ARB_RR_EN for round-robin arbitration;
// without it req 0 has fixed priority over req 1.
module common_reg_arbiter #(
  parameter int          DATA_WIDTH = 8,
  parameter logic [3:0]  IDLE_CODE  = 4'hF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req,
  input  logic [1:0]            op0,
  input  logic [1:0]            op1,
  input  logic [3:0]            src0,
  input  logic [3:0]            src1,
  input  logic [3:0]            dst0,
  input  logic [3:0]            dst1,
  input  logic [DATA_WIDTH-1:0] imm0,
  input  logic [DATA_WIDTH-1:0] imm1,
  output logic [1:0]            ack,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] addr_bus,
  output logic [DATA_WIDTH-1:0] data_bus_in,
  input  logic [DATA_WIDTH-1:0] data_bus_out
);

  localparam logic [1:0] OP_MOVE  = 2'b00;
  localparam logic [1:0] OP_LOADI = 2'b01;

  // Register codes: DR0..DR3 are 0..3, CR is 4; everything above is unmapped.
  localparam logic [3:0] REG_CR = 4'h4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_ACK  = 2'd3
  } state_t;

  state_t                state;
  logic                  gnt;
  logic [1:0]            op_q;
  logic [3:0]            src_q;
  logic [3:0]            dst_q;
  logic [DATA_WIDTH-1:0] imm_q;
  logic [DATA_WIDTH-1:0] hold;

  // Winner of the current arbitration and its operation fields.
  logic                  win;
  logic [1:0]            sel_op;
  logic [3:0]            sel_src;
  logic [3:0]            sel_dst;
  logic [DATA_WIDTH-1:0] sel_imm;

  // Value captured at the end of RD; also becomes the WR-cycle write data.
  logic [DATA_WIDTH-1:0] capture_val;
  logic                  op_writes;

`ifdef COMMON_REG_ARB_RR_EN
  logic last_grant;

  always_comb begin
    win = 1'b0;
    if (req == 2'b11) win = ~last_grant;
    else              win = req[1];
  end
`else
  always_comb begin
    win = ~req[0];
  end
`endif

  always_comb begin
    sel_op  = win ? op1  : op0;
    sel_src = win ? src1 : src0;
    sel_dst = win ? dst1 : dst0;
    sel_imm = win ? imm1 : imm0;
  end

  // Unmapped source codes read as zero, same as the register file default.
  always_comb begin
    capture_val = '0;
    if (op_q == OP_LOADI)    capture_val = imm_q;
    else if (src_q <= REG_CR) capture_val = data_bus_out;
  end

  // MOVE and LOADI write; READ and the reserved code do not.
  assign op_writes = (op_q == OP_MOVE) || (op_q == OP_LOADI);

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      addr_bus    <= DATA_WIDTH'({IDLE_CODE, IDLE_CODE});
      data_bus_in <= '0;
      ack         <= '0;
      rdata       <= '0;
      gnt         <= 1'b0;
      op_q        <= OP_MOVE;
      src_q       <= IDLE_CODE;
      dst_q       <= IDLE_CODE;
      imm_q       <= '0;
      hold        <= '0;
`ifdef COMMON_REG_ARB_RR_EN
      last_grant  <= 1'b1;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          ack <= '0;
          if (|req) begin
            gnt   <= win;
            op_q  <= sel_op;
            src_q <= sel_src;
            dst_q <= sel_dst;
            imm_q <= sel_imm;
            // The bus is registered, so the RD-cycle read select is set
            // here, on the edge that enters RD. LOADI never reads.
            if (sel_op == OP_LOADI)
              addr_bus <= DATA_WIDTH'({IDLE_CODE, IDLE_CODE});
            else
              addr_bus <= DATA_WIDTH'({sel_src, IDLE_CODE});
            data_bus_in <= '0;
            state       <= S_RD;
          end
        end

        S_RD: begin
          hold <= capture_val;
          // data_bus_in takes the same value as hold so the write data is
          // already on the bus for the whole WR cycle.
          if (op_writes) begin
            addr_bus    <= DATA_WIDTH'({IDLE_CODE, dst_q});
            data_bus_in <= capture_val;
          end else begin
            addr_bus    <= DATA_WIDTH'({IDLE_CODE, IDLE_CODE});
            data_bus_in <= '0;
          end
          state <= S_WR;
        end

        S_WR: begin
          // The register file writes on this edge; release the bus after it.
          addr_bus    <= DATA_WIDTH'({IDLE_CODE, IDLE_CODE});
          data_bus_in <= '0;
          if (!op_writes) rdata <= hold;
          ack   <= gnt ? 2'b10 : 2'b01;
          state <= S_ACK;
        end

        S_ACK: begin
          ack <= '0;
`ifdef COMMON_REG_ARB_RR_EN
          last_grant <= gnt;
`endif
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_common_reg_arbiter.sv
// tb_common_reg_arbiter: drives common_reg_arbiter against a behavioural
// register file (DR0..DR3 = codes 0..3, CR = 4) and an abstract model of
// register contents, expected read data and grant order.
module tb_common_reg_arbiter;

  localparam logic [1:0] OP_MOVE  = 2'b00;
  localparam logic [1:0] OP_LOADI = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;

`ifdef COMMON_REG_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req = 2'b00;
  logic [1:0] op0 = 2'b00, op1 = 2'b00;
  logic [3:0] src0 = 4'h0, src1 = 4'h0, dst0 = 4'h0, dst1 = 4'h0;
  logic [7:0] imm0 = 8'h00, imm1 = 8'h00;
  logic [1:0] ack;
  logic [7:0] rdata;
  logic       busy;
  logic [7:0] addr_bus;
  logic [7:0] data_bus_in;
  logic [7:0] data_bus_out;

  int errors = 0;
  int checks = 0;

  // Environment register file: written on the clock edge when the write
  // select addresses a mapped register; unmapped reads return zero.
  logic [7:0] rf [0:4] = '{default: 8'h00};

  // Abstract expectation of register contents and of the last granted side.
  logic [7:0] m [0:4] = '{default: 8'h00};
  int model_last = 1;

  always #5 clk = ~clk;

  common_reg_arbiter #(.DATA_WIDTH(8), .IDLE_CODE(4'hF)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .op0          (op0),
    .op1          (op1),
    .src0         (src0),
    .src1         (src1),
    .dst0         (dst0),
    .dst1         (dst1),
    .imm0         (imm0),
    .imm1         (imm1),
    .ack          (ack),
    .rdata        (rdata),
    .busy         (busy),
    .addr_bus     (addr_bus),
    .data_bus_in  (data_bus_in),
    .data_bus_out (data_bus_out)
  );

  assign data_bus_out = (addr_bus[7:4] <= 4'd4) ? rf[addr_bus[6:4]] : 8'h00;

  always @(posedge clk) begin
    if (addr_bus[3:0] <= 4'd4) rf[addr_bus[2:0]] <= data_bus_in;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mread(input logic [3:0] code);
    return (code <= 4'd4) ? m[code[2:0]] : 8'h00;
  endfunction

  function automatic logic [3:0] pick_code();
    int x;
    x = $urandom_range(0, 7);
    return (x < 5) ? 4'(x) : 4'($urandom_range(0, 15));
  endfunction

  task automatic check_rf();
    for (int k = 0; k < 5; k++) check_eq("regfile", rf[k], m[k]);
  endtask

  // At most one nibble of the address bus may select a register at a time.
  always @(negedge clk) begin
    if (!rst) check_eq("one_nibble", (addr_bus[7:4] == 4'hF) || (addr_bus[3:0] == 4'hF), 1);
  end

  // One transfer from requester r, started while the arbiter is idle.
  // drop_at > 0 releases req that many cycles after it was sampled.
  task automatic xfer(input int r, input logic [1:0] op, input logic [3:0] src,
                      input logic [3:0] dst, input logic [7:0] imm, input int drop_at);
    logic [7:0] exp_val;
    bit         writes;
    int         n;
    if (r == 0) begin op0 = op; src0 = src; dst0 = dst; imm0 = imm; end
    else        begin op1 = op; src1 = src; dst1 = dst; imm1 = imm; end
    writes  = (op == OP_MOVE) || (op == OP_LOADI);
    exp_val = (op == OP_LOADI) ? imm : mread(src);
    req[r]  = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == drop_at) req[r] = 1'b0;
      if (n == 1) check_eq("rd_addr", addr_bus, (op == OP_LOADI) ? 8'hFF : {src, 4'hF});
      if (n == 2) begin
        check_eq("wr_addr", addr_bus, writes ? {4'hF, dst} : 8'hFF);
        check_eq("wr_data", data_bus_in, writes ? exp_val : 8'h00);
      end
    end while (ack == 2'b00 && n < 12);
    check_eq("latency", n, 3);
    check_eq("ack", ack, 2'b01 << r);
    check_eq("busy_ack", busy, 1);
    if (writes && dst <= 4'd4) m[dst[2:0]] = exp_val;
    if (!writes) check_eq("rdata", rdata, exp_val);
    model_last = r;
    check_rf();
    req[r] = 1'b0;
    @(negedge clk);
    check_eq("ack_once", ack, 0);
    check_eq("busy_idle", busy, 0);
  endtask

  // Both requesters hold LOADI requests for nxfer back-to-back transfers.
  task automatic contend(input int nxfer);
    logic [7:0] i0, i1;
    int n, w;
    i0 = 8'($urandom); i1 = 8'($urandom);
    op0 = OP_LOADI; dst0 = 4'd2; imm0 = i0;
    op1 = OP_LOADI; dst1 = 4'd4; imm1 = i1;
    req = 2'b11;
    for (int k = 0; k < nxfer; k++) begin
      w = (RR && model_last == 0) ? 1 : 0;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (ack == 2'b00 && n < 12);
      check_eq("ack_spacing", n, (k == 0) ? 3 : 4);
      check_eq("grant", ack, 2'b01 << w);
      if (w == 0) m[2] = i0; else m[4] = i1;
      model_last = w;
      check_rf();
    end
    req = 2'b00;
    @(negedge clk);
    check_eq("contend_end", ack, 0);
  endtask

  // Reset asserted `phase` cycles into a LOADI (1 = RD, 2 = WR).
  task automatic reset_mid(input int phase);
    op0 = OP_LOADI; dst0 = 4'd0; imm0 = m[0] ^ 8'hFF;
    req = 2'b01;
    repeat (phase) @(negedge clk);
    check_eq("busy_pre_rst", busy, 1);
    rst = 1'b1;
    #1;
    check_eq("rst_addr", addr_bus, 8'hFF);
    check_eq("rst_ack", ack, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_data", data_bus_in, 0);
    req = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    model_last = 1;
    repeat (4) begin
      @(negedge clk);
      check_eq("no_ack_after_rst", ack, 0);
    end
    check_rf();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check_eq("reset_addr", addr_bus, 8'hFF);
    check_eq("reset_data", data_bus_in, 0);
    check_eq("reset_ack", ack, 0);
    check_eq("reset_rdata", rdata, 0);
    check_eq("reset_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed: load, move, read back, boundary codes, early release.
    xfer(0, OP_LOADI, 4'h0, 4'd1, 8'hA5, 0);
    xfer(1, OP_MOVE,  4'd1, 4'd3, 8'h00, 0);
    xfer(1, OP_READ,  4'd3, 4'h0, 8'h00, 0);
    check_eq("dr3_value", rf[3], 8'hA5);
    xfer(0, OP_READ,  4'h9, 4'h0, 8'h00, 0);
    xfer(0, OP_LOADI, 4'h0, 4'hF, 8'h3C, 0);
    xfer(0, 2'b11,    4'd1, 4'h0, 8'h00, 0);
    xfer(1, OP_MOVE,  4'd3, 4'd3, 8'h00, 0);
    xfer(0, OP_LOADI, 4'h0, 4'd4, 8'h5A, 2);
    xfer(1, OP_READ,  4'd4, 4'h0, 8'h00, 1);

    contend(4);
    reset_mid(1);
    contend(4);
    reset_mid(2);

    // Randomized traffic, occasionally with contention bursts.
    for (int t = 0; t < 60; t++) begin
      int drop;
      drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      if (t % 15 == 14) contend(int'($urandom_range(2, 4)));
      else xfer(int'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                pick_code(), pick_code(), 8'($urandom), drop);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
